network_run_scheduler: RTL and testbench
========================================

Name: network_run_scheduler

Overview:
Command-driven controller that sequences network timesteps. It accepts a command stream (NOP, SPK, RUN, CLR), accumulates input charges into a pending buffer, and replays them as the first of N timesteps over a valid/ready handshake to the network. It pulses a clear to the network on CLR and signals completion of each RUN. It sits between the host/stream decoder and the network core, in place of a simple pass-through source.

Parameters:
NUM_INP, network_config::NET_NUM_INP, number of network input neurons
CHARGE_WIDTH, network_config::NET_CHARGE_WIDTH, signed charge width per input
RUN_WIDTH, 16, width of RUN timestep count

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd  input  OPC_WIDTH+PAYLOAD_WIDTH  {opcode, payload}; opcode in MSBs
net_ready  input  1  network can consume a timestep
net_valid  output  1  timestep available to network
net_clr  output  1  one-cycle network state clear, active-high
net_inp  output  NUM_INP x CHARGE_WIDTH signed  per-input charge for the current timestep
run_done  output  1  one-cycle pulse after the last timestep of a RUN
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, pending[*]=0, remaining=0, net_valid=0, net_clr=0, run_done=0, net_inp=0, busy=0. Reset mid-RUN abandons the run with no run_done pulse.
- Payload field i (charge for input i) = payload[(NUM_INP-i)*CHARGE_WIDTH-1 -: CHARGE_WIDTH], so input 0 is in the MSBs. RUN count = payload[RUN_WIDTH-1:0]; other payload bits are ignored.
- net_inp is driven directly by the pending register array.
- States: IDLE, RUN, CLEAR.
- IDLE: cmd_ready=1, net_valid=0. On accept:
  - NOP: no effect.
  - SPK: pending[i] <= sat(pending[i] + field i) for all i. Add at CHARGE_WIDTH+1 bits, clamp to [-2^(CW-1), 2^(CW-1)-1]. Result is visible the next cycle; back-to-back SPK accepts accumulate.
  - RUN, N=0: stay IDLE; run_done=1 next cycle; pending unchanged.
  - RUN, N>0: remaining <= N; go to RUN next cycle.
  - CLR: pending <= 0; go to CLEAR.
- RUN: cmd_ready=0, net_valid=1.
  - On fire (net_valid && net_ready): remaining <= remaining-1, pending <= 0. The first timestep therefore carries the accumulated charges; later timesteps carry zero.
  - While net_ready=0, net_inp and remaining hold.
  - On the fire with remaining==1: go to IDLE; run_done=1 in the following cycle, which is also the first cycle cmd_ready=1.
  - Latency: RUN accepted at cycle t gives net_valid from t+1. With net_ready held high, timesteps fire at t+1..t+N and run_done is asserted at t+N+1.
- CLEAR: net_clr=1 for exactly one cycle, cmd_ready=0, net_valid=0; return to IDLE.
- net_clr and run_done are registered, never asserted together, and only ever one cycle wide.
- Max run length is 2^RUN_WIDTH-1; the count does not wrap.

Decomposition:
- Package run_scheduler_config (imports network_config):
  - opcode_t enum {NOP=0, SPK=1, RUN=2, CLR=3}
  - OPC_WIDTH=2
  - PAYLOAD_WIDTH = max(RUN_WIDTH, NET_NUM_INP*NET_CHARGE_WIDTH)
  - state_t enum {IDLE, RUN, CLEAR}
- Sub-module charge_sat_add: parameter CHARGE_WIDTH; signed a, b -> saturated sum. Instantiated NUM_INP times.

Test Plan:
1. Reset: assert rst 2 cycles during arbitrary cmd/net_ready -> all outputs 0, busy=0, cmd_ready=1 after deassert.
2. Saturation (CW=8, NUM_INP=4): SPK {5,-3,0,127} then SPK {10,-128,-1,1} -> net_inp={15,-128,-1,127} after 2nd accept; then SPK {0,-1,0,0} -> input1 stays -128.
3. RUN 3, net_ready=1: after SPK {1,2,3,4} -> net_valid high 3 cycles, net_inp {1,2,3,4} then {0,0,0,0} x2; run_done exactly 1 cycle after 3rd fire; cmd_ready=0 throughout the run.
4. Backpressure: RUN 2 with net_ready low 2 cycles, then high -> net_inp held at pending while stalled; exactly 2 fires; run_done once.
5. CLR after SPK {7,7,7,7} -> net_clr high exactly 1 cycle, cmd_ready=0 that cycle, net_inp=0 next cycle; a CLR presented during RUN is not accepted until run_done.
6. RUN 0 -> no net_valid, run_done next cycle. RUN 5 with rst asserted after 2 fires -> no run_done; IDLE, pending=0.

Source files
------------

// File: rtl/network_run_scheduler_pkg.sv
// Shared configuration for the network run scheduler: network geometry,
// command opcodes, scheduler states and derived command widths.
package network_config;
   localparam int NET_NUM_INP      = 4;
   localparam int NET_CHARGE_WIDTH = 8;
endpackage

package run_scheduler_config;
   import network_config::*;

   function automatic int max_int(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   typedef enum logic [1:0] {
      OPC_NOP = 2'd0,
      OPC_SPK = 2'd1,
      OPC_RUN = 2'd2,
      OPC_CLR = 2'd3
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam int SCHED_RUN_WIDTH = 16;
   localparam int OPC_WIDTH       = 2;
   localparam int PAYLOAD_WIDTH   = max_int(SCHED_RUN_WIDTH, NET_NUM_INP * NET_CHARGE_WIDTH);
   localparam int CMD_WIDTH       = OPC_WIDTH + PAYLOAD_WIDTH;
endpackage

// File: rtl/network_run_scheduler_if.sv
// Command stream and network-side handshake bundle of the run scheduler.
interface network_run_scheduler_if #(
   parameter int NUM_INP      = network_config::NET_NUM_INP,
   parameter int CHARGE_WIDTH = network_config::NET_CHARGE_WIDTH,
   parameter int CMD_WIDTH    = run_scheduler_config::CMD_WIDTH
);
   logic                           cmd_valid;
   logic                           cmd_ready;
   logic [CMD_WIDTH-1:0]           cmd;
   logic                           net_ready;
   logic                           net_valid;
   logic                           net_clr;
   logic signed [CHARGE_WIDTH-1:0] net_inp [NUM_INP];
   logic                           run_done;
   logic                           busy;

   // host / network side
   modport master (
      output cmd_valid, cmd, net_ready,
      input  cmd_ready, net_valid, net_clr, net_inp, run_done, busy
   );

   // scheduler side
   modport slave (
      input  cmd_valid, cmd, net_ready,
      output cmd_ready, net_valid, net_clr, net_inp, run_done, busy
   );
endinterface

// File: rtl/network_run_scheduler_charge_sat_add.sv
// Signed adder that clamps the sum of two charges to the representable range.
module charge_sat_add #(
   parameter int CHARGE_WIDTH = 8
) (
   input  logic signed [CHARGE_WIDTH-1:0] a,
   input  logic signed [CHARGE_WIDTH-1:0] b,
   output logic signed [CHARGE_WIDTH-1:0] sum
);
   localparam logic [CHARGE_WIDTH-1:0] CHARGE_MAX = {1'b0, {(CHARGE_WIDTH-1){1'b1}}};
   localparam logic [CHARGE_WIDTH-1:0] CHARGE_MIN = {1'b1, {(CHARGE_WIDTH-1){1'b0}}};

   logic signed [CHARGE_WIDTH:0] wide_s;

   assign wide_s = {a[CHARGE_WIDTH-1], a} + {b[CHARGE_WIDTH-1], b};

   // Overflow shows as disagreement between the extra sign bit and the result MSB.
   always_comb begin
      sum = wide_s[CHARGE_WIDTH-1:0];
      if (wide_s[CHARGE_WIDTH] != wide_s[CHARGE_WIDTH-1]) begin
         if (wide_s[CHARGE_WIDTH]) begin
            sum = CHARGE_MIN;
         end else begin
            sum = CHARGE_MAX;
         end
      end else begin
         sum = wide_s[CHARGE_WIDTH-1:0];
      end
   end
endmodule

// File: rtl/network_run_scheduler.sv
// Command-driven sequencer: accumulates input charges, replays them as the
// first of N network timesteps, and issues network clears and run completion.
module network_run_scheduler
   import run_scheduler_config::*;
#(
   parameter int NUM_INP      = network_config::NET_NUM_INP,
   parameter int CHARGE_WIDTH = network_config::NET_CHARGE_WIDTH,
   parameter int RUN_WIDTH    = 16
) (
   input logic                    clk,
   input logic                    rst,
   network_run_scheduler_if.slave bus
);
   localparam int PAY_W = max_int(RUN_WIDTH, NUM_INP * CHARGE_WIDTH);
   localparam int CMD_W = OPC_WIDTH + PAY_W;
   localparam logic [RUN_WIDTH-1:0]    RUN_ZERO    = {RUN_WIDTH{1'b0}};
   localparam logic [RUN_WIDTH-1:0]    RUN_ONE     = {{(RUN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CHARGE_WIDTH-1:0] CHARGE_ZERO = {CHARGE_WIDTH{1'b0}};

   state_t                         state_r;
   state_t                         state_next_s;
   logic [RUN_WIDTH-1:0]           remaining_r;
   logic [RUN_WIDTH-1:0]           remaining_next_s;
   logic signed [CHARGE_WIDTH-1:0] pending_r      [NUM_INP];
   logic signed [CHARGE_WIDTH-1:0] pending_next_s [NUM_INP];
   logic signed [CHARGE_WIDTH-1:0] field_s        [NUM_INP];
   logic signed [CHARGE_WIDTH-1:0] sum_s          [NUM_INP];
   logic                           run_done_r;
   logic                           run_done_next_s;
   logic                           net_clr_r;
   logic                           net_valid_r;
   logic                           cmd_ready_r;
   logic                           busy_r;
   opcode_t                        opc_s;
   logic [PAY_W-1:0]               payload_s;
   logic [RUN_WIDTH-1:0]           run_cnt_s;
   logic                           accept_s;
   logic                           fire_s;

   assign opc_s     = opcode_t'(bus.cmd[CMD_W-1 -: OPC_WIDTH]);
   assign payload_s = bus.cmd[PAY_W-1:0];
   assign run_cnt_s = payload_s[RUN_WIDTH-1:0];
   assign accept_s  = bus.cmd_valid && cmd_ready_r;
   assign fire_s    = net_valid_r && bus.net_ready;

   // Input 0 sits in the payload MSBs; each lane gets its own saturating adder.
   for (genvar gi = 0; gi < NUM_INP; gi++) begin : g_lane
      assign field_s[gi] = payload_s[(NUM_INP-gi)*CHARGE_WIDTH-1 -: CHARGE_WIDTH];

      charge_sat_add #(.CHARGE_WIDTH(CHARGE_WIDTH)) u_sat_add (
         .a   (pending_r[gi]),
         .b   (field_s[gi]),
         .sum (sum_s[gi])
      );

      assign bus.net_inp[gi] = pending_r[gi];
   end

   assign bus.cmd_ready = cmd_ready_r;
   assign bus.net_valid = net_valid_r;
   assign bus.net_clr   = net_clr_r;
   assign bus.run_done  = run_done_r;
   assign bus.busy      = busy_r;

   // Next-state, run counter and pending-charge update.
   always_comb begin
      state_next_s     = state_r;
      remaining_next_s = remaining_r;
      run_done_next_s  = 1'b0;
      for (int i = 0; i < NUM_INP; i++) begin
         pending_next_s[i] = pending_r[i];
      end
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               case (opc_s)
                  OPC_NOP: begin
                     state_next_s = ST_IDLE;
                  end
                  OPC_SPK: begin
                     for (int i = 0; i < NUM_INP; i++) begin
                        pending_next_s[i] = sum_s[i];
                     end
                  end
                  OPC_RUN: begin
                     if (run_cnt_s == RUN_ZERO) begin
                        run_done_next_s = 1'b1;
                     end else begin
                        remaining_next_s = run_cnt_s;
                        state_next_s     = ST_RUN;
                     end
                  end
                  OPC_CLR: begin
                     for (int i = 0; i < NUM_INP; i++) begin
                        pending_next_s[i] = CHARGE_ZERO;
                     end
                     state_next_s = ST_CLEAR;
                  end
                  default: begin
                     state_next_s = ST_IDLE;
                  end
               endcase
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Only the first timestep carries charge; later ones replay zeros.
            if (fire_s) begin
               remaining_next_s = remaining_r - RUN_ONE;
               for (int i = 0; i < NUM_INP; i++) begin
                  pending_next_s[i] = CHARGE_ZERO;
               end
               if (remaining_r == RUN_ONE) begin
                  state_next_s    = ST_IDLE;
                  run_done_next_s = 1'b1;
               end else begin
                  state_next_s = ST_RUN;
               end
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_CLEAR: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         remaining_r <= RUN_ZERO;
         for (int i = 0; i < NUM_INP; i++) begin
            pending_r[i] <= CHARGE_ZERO;
         end
         run_done_r  <= 1'b0;
         net_clr_r   <= 1'b0;
         net_valid_r <= 1'b0;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         remaining_r <= remaining_next_s;
         for (int i = 0; i < NUM_INP; i++) begin
            pending_r[i] <= pending_next_s[i];
         end
         run_done_r  <= run_done_next_s;
         net_clr_r   <= (state_next_s == ST_CLEAR);
         net_valid_r <= (state_next_s == ST_RUN);
         cmd_ready_r <= (state_next_s == ST_IDLE);
         busy_r      <= (state_next_s != ST_IDLE);
      end
   end
endmodule

// File: tb/tb_network_run_scheduler.sv
// Directed bench for network_run_scheduler: per-cycle vector table plus
// hand-written RUN sequences under randomized backpressure.
module tb_network_run_scheduler;
   import run_scheduler_config::*;

   typedef struct {
      logic          rst;
      logic          cv;
      opcode_t       opc;
      logic [31:0]   pay;
      logic          nr;
      logic [36:0]   exp;
   } vec_t;

   logic   clk;
   logic   rst;
   int     tests;
   int     fails;
   vec_t   vecs[$];

   network_run_scheduler_if bus ();

   network_run_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      logic [7:0] x0, x1, x2, x3;
      x0 = a[7:0];
      x1 = b[7:0];
      x2 = c[7:0];
      x3 = d[7:0];
      return {x0, x1, x2, x3};
   endfunction

   function automatic vec_t mk(input logic r, input logic cv, input opcode_t op,
                               input logic [31:0] pay, input logic nr, input logic [31:0] ei,
                               input logic ev, input logic ec, input logic ed,
                               input logic er, input logic eb);
      vec_t v;
      v.rst = r;
      v.cv  = cv;
      v.opc = op;
      v.pay = pay;
      v.nr  = nr;
      v.exp = {ei, ev, ec, ed, er, eb};
      return v;
   endfunction

   function automatic logic [36:0] observe();
      return {bus.net_inp[0], bus.net_inp[1], bus.net_inp[2], bus.net_inp[3],
              bus.net_valid, bus.net_clr, bus.run_done, bus.cmd_ready, bus.busy};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RUN of n timesteps with random net_ready; upper payload bits must be ignored.
   task automatic run_seq(input int n, input logic [15:0] hi);
      int   fires;
      int   cyc;
      logic seen_done;
      logic ready_low;
      logic clr_seen;
      logic nr;
      logic [15:0] cnt;
      fires     = 0;
      cyc       = 0;
      seen_done = 1'b0;
      ready_low = 1'b1;
      clr_seen  = 1'b0;
      cnt       = n[15:0];
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd       = {OPC_RUN, hi, cnt};
      bus.net_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd       = {OPC_CLR, 32'h0000_0000};
      while (!seen_done && cyc < 200) begin
         @(negedge clk);
         nr = 1'($urandom_range(0, 1));
         bus.net_ready = nr;
         if (bus.net_valid && nr) fires++;
         if (bus.cmd_ready) ready_low = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
         if (bus.net_clr) clr_seen = 1'b1;
         if (bus.run_done) seen_done = 1'b1;
      end
      check($sformatf("run%0d_done_seen", n), {63'd0, seen_done}, 64'd1);
      check($sformatf("run%0d_fires", n), 64'(fires), 64'(n));
      check($sformatf("run%0d_ready_low", n), {63'd0, ready_low}, 64'd1);
      check($sformatf("run%0d_no_clr", n), {63'd0, clr_seen}, 64'd0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.net_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("run%0d_after", n), {27'd0, observe()}, {27'd0, 32'h0, 5'b00010});
   endtask

   initial begin
      logic [31:0] z;
      logic [31:0] p;
      tests = 0;
      fails = 0;
      rst           = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd       = {OPC_SPK, 32'h1111_1111};
      bus.net_ready = 1'b1;
      z = 32'h0;
      p = pk(-5, 6, -7, 8);

      // reset held two cycles with live stimulus
      vecs.push_back(mk(1, 1, OPC_SPK, pk(9, 9, 9, 9), 1, z, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 1, OPC_RUN, 32'd5, 0, z, 0, 0, 0, 1, 0));
      // saturating accumulation
      vecs.push_back(mk(0, 1, OPC_SPK, pk(5, -3, 0, 127), 0, pk(5, -3, 0, 127), 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, OPC_SPK, pk(10, -128, -1, 1), 0, pk(15, -128, -1, 127), 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, OPC_SPK, pk(0, -1, 0, 0), 0, pk(15, -128, -1, 127), 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, OPC_NOP, pk(3, 3, 3, 3), 0, pk(15, -128, -1, 127), 0, 0, 0, 1, 0));
      // clear
      vecs.push_back(mk(0, 1, OPC_CLR, z, 0, z, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, OPC_SPK, pk(9, 9, 9, 9), 0, z, 0, 0, 0, 1, 0));
      // RUN 3 with ready high; CLR held off until run_done
      vecs.push_back(mk(0, 1, OPC_SPK, pk(1, 2, 3, 4), 1, pk(1, 2, 3, 4), 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, OPC_RUN, 32'd3, 1, pk(1, 2, 3, 4), 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, OPC_CLR, z, 1, z, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, OPC_CLR, z, 1, z, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, OPC_CLR, z, 1, z, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 1, OPC_CLR, z, 1, z, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, z, 0, 0, 0, 1, 0));
      // RUN 2 under backpressure
      vecs.push_back(mk(0, 1, OPC_SPK, p, 0, p, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, OPC_RUN, 32'd2, 0, p, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 0, p, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 0, p, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, z, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, z, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, z, 0, 0, 0, 1, 0));
      // RUN 0 keeps pending; RUN 5 abandoned by reset
      vecs.push_back(mk(0, 1, OPC_SPK, pk(1, 1, 1, 1), 1, pk(1, 1, 1, 1), 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, OPC_RUN, 32'd0, 1, pk(1, 1, 1, 1), 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, pk(1, 1, 1, 1), 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, OPC_RUN, 32'd5, 1, pk(1, 1, 1, 1), 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, z, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, z, 1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, OPC_NOP, z, 1, z, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, z, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, OPC_NOP, z, 1, z, 0, 0, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst           = vecs[i].rst;
         bus.cmd_valid = vecs[i].cv;
         bus.cmd       = {vecs[i].opc, vecs[i].pay};
         bus.net_ready = vecs[i].nr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), {27'd0, observe()}, {27'd0, vecs[i].exp});
      end

      run_seq(1, 16'h0000);
      run_seq(4, 16'hA5C3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
